cmd_phy_controller: RTL and testbench
=====================================

// Module: cmd_phy_controller
// PURPOSE
//  Parametrised successor to the SD CMD-line physical-layer sequencer. Sits between CMD host logic and
//  P->S / S->P wrappers + PAD: loads/sends a command, waits for a short or long response with a
//  parametrised Ncr timeout, and returns it through a full strobe/ack handshake. All outputs registered.
// PARAMETERS
//  RESP_W          136  width of response bus (long response, R2)
//  SHORT_W         48   significant bits of a short response (R1/R3/R6/R7)
//  TIMEOUT_CYCLES  64   sd_clock cycles in WAIT_RESP before command_timeout
//  MAX_RETRY       2    command re-sends after timeout (used only with CMD_RETRY_EN)
// PORTS
//  sd_clock               in   1       card clock; all state on rising edge
//  reset                  in   1       asynchronous, active-low reset
//  strobe_in              in   1       CMD requests a transaction; held until ack_out
//  ack_in                 in   1       CMD accepted response; held until strobe_out drops
//  idle_in                in   1       abort: return to IDLE
//  no_response            in   1       command has no response (sampled with strobe_in)
//  long_resp              in   1       1: RESP_W-bit response, 0: SHORT_W-bit (sampled with strobe_in)
//  pad_response           in   RESP_W  frame from S->P wrapper
//  reception_complete     in   1       S->P wrapper frame done
//  transmission_complete  in   1       P->S wrapper frame done
//  ack_out                out  1       transaction closed toward CMD
//  strobe_out             out  1       response/timeout available
//  response               out  RESP_W  captured frame
//  command_timeout        out  1       timeout flag, valid while strobe_out=1
//  load_send              out  1       P->S: 0 load, 1 shift
//  enable_pts_wrapper     out  1       enable P->S
//  enable_stp_wrapper     out  1       enable S->P
//  reset_wrapper          out  1       1 holds both wrappers cleared
//  pad_state              out  1       1 drive CMD, 0 receive
//  pad_enable             out  1       PAD enable
//  long_mode              out  1       latched long_resp to S->P wrapper (frame length select)
// BEHAVIOUR
//  Reset (reset=0): state IDLE, all outputs 0 except reset_wrapper=1; counters 0.
//  IDLE: reset_wrapper=1, other outputs 0. strobe_in=1 & idle_in=0 -> LOAD; latch no_response, long_resp.
//  LOAD (1 cycle): reset_wrapper=0, enable_pts_wrapper=1, pad_state=1, pad_enable=1, load_send=0 -> SEND.
//  SEND: load_send=1 until transmission_complete=1; then no_response latched -> DELIVER (response=0,
//   command_timeout=0), else -> WAIT_RESP.
//  WAIT_RESP: pad_enable=0, pad_state=0, enable_pts_wrapper=0, enable_stp_wrapper=1; counter +1 per cycle.
//   reception_complete=1 -> capture: long: response=pad_response; short: response[SHORT_W-1:0]=
//   pad_response[SHORT_W-1:0], upper bits 0; -> DELIVER.
//   counter==TIMEOUT_CYCLES-1 without reception -> command_timeout=1, response=0, -> DELIVER.
//   reception_complete in the timeout cycle: reception wins, no timeout.
//  DELIVER/WAIT_ACK: strobe_out=1, response/command_timeout held; wrappers disabled. ack_in=1 -> ACK.
//  ACK: strobe_out=0, ack_out=1 held until strobe_in=0, then -> IDLE (ack_out 0 next cycle).
//  Minimum latency strobe_in -> strobe_out, no-response command: 3 cycles + transmission time.
//  idle_in=1 in any state except IDLE: next cycle IDLE, outputs to IDLE values, counters cleared,
//   response and command_timeout cleared.
//  Counter width $clog2(TIMEOUT_CYCLES+1); saturates; cleared on every WAIT_RESP entry.
// CONFIGURATION
//  CMD_RETRY_EN defined: timeout in WAIT_RESP with retry_cnt<MAX_RETRY -> retry_cnt+1, back to LOAD
//   (no strobe_out); command_timeout only when retries exhausted. retry_cnt cleared in IDLE.
//  CMD_RETRY_EN undefined: first timeout reported directly; no retry counter present.
// STRUCTURE
//  Package sd_cmd_pkg: state enum (IDLE, LOAD, SEND, WAIT_RESP, DELIVER, WAIT_ACK, ACK),
//   default RESP_W/SHORT_W constants.
//  One sub-module: cmd_timeout_counter (clear, enable, terminal-count pulse).
// TESTING
//  Short resp: strobe_in, long_resp=0, pad_response=136'hFF..FF, reception_complete 5 cycles
//   after SEND -> response=136'h0000_FFFF_FFFF_FFFF, strobe_out=1, command_timeout=0.
//  Long resp: long_resp=1, pad_response=136'hA5A5... -> response identical, long_mode=1.
//  Timeout: TIMEOUT_CYCLES=8, no reception -> command_timeout=1 exactly 8 cycles after WAIT_RESP entry.
//  Tie: reception_complete on 8th cycle -> command_timeout=0, response captured.
//  no_response=1 -> WAIT_RESP skipped, strobe_out after transmission_complete, response=0.
//  idle_in mid-SEND -> IDLE next cycle, pad_enable=0, reset_wrapper=1; CMD_RETRY_EN, MAX_RETRY=2:
//   3 LOAD entries before command_timeout=1; reset=0 mid-WAIT_RESP -> all outputs reset values at once.

Source files
------------

// File: rtl/sd_cmd_pkg.sv
// Shared types and defaults for the SD CMD-line physical-layer sequencer.
// Contents: FSM state enum, wrapper/PAD control bundle, default bus widths.
package sd_cmd_pkg;

  localparam int unsigned RESP_W_DEF  = 136;
  localparam int unsigned SHORT_W_DEF = 48;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    SEND      = 3'd2,
    WAIT_RESP = 3'd3,
    DELIVER   = 3'd4,
    WAIT_ACK  = 3'd5,
    ACK       = 3'd6
  } cmd_state_e;

  // Control bundle toward the P->S / S->P wrappers and the CMD pad
  typedef struct packed {
    logic load_send;
    logic enable_pts_wrapper;
    logic enable_stp_wrapper;
    logic reset_wrapper;
    logic pad_state;
    logic pad_enable;
  } phy_ctrl_t;

endpackage

// File: rtl/cmd_timeout_counter.sv
// Ncr response-timeout counter.
// Ports: sd_clock/reset (async active-low), clear (synchronous zero),
//        enable (count one per cycle, saturating), term_c (combinational,
//        high in the last allowed cycle while enabled).
module cmd_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic sd_clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic term_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;

  // Saturating up-counter
  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != CNT_W'(TIMEOUT_CYCLES))) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign term_c = enable && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/cmd_phy_controller.sv
// SD CMD-line physical-layer sequencer: loads and sends a command through the
// P->S wrapper, waits for a short/long response with an Ncr timeout, and
// returns it to the CMD host with a strobe/ack handshake.
// Inputs : sd_clock, reset (async active-low), strobe_in, ack_in, idle_in,
//          no_response, long_resp, pad_response, reception_complete,
//          transmission_complete.
// Outputs (all registered): ack_out, strobe_out, response, command_timeout,
//          load_send, enable_pts_wrapper, enable_stp_wrapper, reset_wrapper,
//          pad_state, pad_enable, long_mode.
// Build option: CMD_RETRY_EN re-sends the command up to MAX_RETRY times on
//          timeout before reporting command_timeout.
module cmd_phy_controller
  import sd_cmd_pkg::*;
#(
  parameter int unsigned RESP_W         = RESP_W_DEF,
  parameter int unsigned SHORT_W        = SHORT_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned MAX_RETRY      = 2
) (
  input  logic              sd_clock,
  input  logic              reset,
  input  logic              strobe_in,
  input  logic              ack_in,
  input  logic              idle_in,
  input  logic              no_response,
  input  logic              long_resp,
  input  logic [RESP_W-1:0] pad_response,
  input  logic              reception_complete,
  input  logic              transmission_complete,
  output logic              ack_out,
  output logic              strobe_out,
  output logic [RESP_W-1:0] response,
  output logic              command_timeout,
  output logic              load_send,
  output logic              enable_pts_wrapper,
  output logic              enable_stp_wrapper,
  output logic              reset_wrapper,
  output logic              pad_state,
  output logic              pad_enable,
  output logic              long_mode
);

  cmd_state_e        state_q, state_d;
  phy_ctrl_t         ctrl_q, ctrl_d;
  logic              strobe_d, ack_d, timeout_d, long_d;
  logic              no_resp_q, no_resp_d;
  logic [RESP_W-1:0] resp_d;
  logic              term_c;

`ifdef CMD_RETRY_EN
  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RETRY_W-1:0] retry_q, retry_d;
`else
  // Retry limit has no effect without the retry feature
  logic unused_retry_cfg;
  assign unused_retry_cfg = (MAX_RETRY != 0);
`endif

  // Counter runs only in WAIT_RESP, so every entry starts from zero
  cmd_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .sd_clock(sd_clock),
    .reset   (reset),
    .clear   (state_q != WAIT_RESP),
    .enable  (state_q == WAIT_RESP),
    .term_c  (term_c)
  );

  // State and registered outputs
  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      ctrl_q          <= '{reset_wrapper: 1'b1, default: 1'b0};
      strobe_out      <= 1'b0;
      ack_out         <= 1'b0;
      response        <= '0;
      command_timeout <= 1'b0;
      long_mode       <= 1'b0;
      no_resp_q       <= 1'b0;
`ifdef CMD_RETRY_EN
      retry_q         <= '0;
`endif
    end else begin
      state_q         <= state_d;
      ctrl_q          <= ctrl_d;
      strobe_out      <= strobe_d;
      ack_out         <= ack_d;
      response        <= resp_d;
      command_timeout <= timeout_d;
      long_mode       <= long_d;
      no_resp_q       <= no_resp_d;
`ifdef CMD_RETRY_EN
      retry_q         <= retry_d;
`endif
    end
  end

  // Next state, captured data, and outputs decoded from the next state
  always_comb begin
    state_d   = state_q;
    resp_d    = response;
    timeout_d = command_timeout;
    long_d    = long_mode;
    no_resp_d = no_resp_q;
    ctrl_d    = '0;
    strobe_d  = 1'b0;
    ack_d     = 1'b0;
`ifdef CMD_RETRY_EN
    retry_d   = retry_q;
`endif

    case (state_q)
      IDLE: begin
        if (strobe_in && !idle_in) begin
          state_d   = LOAD;
          no_resp_d = no_response;
          long_d    = long_resp;
        end
      end
      LOAD: state_d = SEND;
      SEND: begin
        if (transmission_complete) begin
          if (no_resp_q) begin
            state_d   = DELIVER;
            resp_d    = '0;
            timeout_d = 1'b0;
          end else begin
            state_d = WAIT_RESP;
          end
        end
      end
      WAIT_RESP: begin
        // A frame completing in the terminal cycle beats the timeout
        if (reception_complete) begin
          state_d   = DELIVER;
          timeout_d = 1'b0;
          resp_d    = long_mode ? pad_response
                                : RESP_W'(pad_response[SHORT_W-1:0]);
        end else if (term_c) begin
`ifdef CMD_RETRY_EN
          if (retry_q < RETRY_W'(MAX_RETRY)) begin
            state_d = LOAD;
            retry_d = retry_q + RETRY_W'(1);
          end else begin
            state_d   = DELIVER;
            timeout_d = 1'b1;
            resp_d    = '0;
          end
`else
          state_d   = DELIVER;
          timeout_d = 1'b1;
          resp_d    = '0;
`endif
        end
      end
      DELIVER:  state_d = ack_in ? ACK : WAIT_ACK;
      WAIT_ACK: if (ack_in) state_d = ACK;
      ACK:      if (!strobe_in) state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    // Abort from any active state
    if (idle_in && (state_q != IDLE)) state_d = IDLE;

    if (state_d == IDLE) begin
      resp_d    = '0;
      timeout_d = 1'b0;
      long_d    = 1'b0;
      no_resp_d = 1'b0;
`ifdef CMD_RETRY_EN
      retry_d   = '0;
`endif
    end

    case (state_d)
      IDLE: ctrl_d.reset_wrapper = 1'b1;
      LOAD: begin
        ctrl_d.enable_pts_wrapper = 1'b1;
        ctrl_d.pad_state          = 1'b1;
        ctrl_d.pad_enable         = 1'b1;
      end
      SEND: begin
        ctrl_d.load_send          = 1'b1;
        ctrl_d.enable_pts_wrapper = 1'b1;
        ctrl_d.pad_state          = 1'b1;
        ctrl_d.pad_enable         = 1'b1;
      end
      WAIT_RESP:         ctrl_d.enable_stp_wrapper = 1'b1;
      DELIVER, WAIT_ACK: strobe_d = 1'b1;
      ACK:               ack_d    = 1'b1;
      default:           ctrl_d.reset_wrapper = 1'b1;
    endcase
  end

  assign load_send          = ctrl_q.load_send;
  assign enable_pts_wrapper = ctrl_q.enable_pts_wrapper;
  assign enable_stp_wrapper = ctrl_q.enable_stp_wrapper;
  assign reset_wrapper      = ctrl_q.reset_wrapper;
  assign pad_state          = ctrl_q.pad_state;
  assign pad_enable         = ctrl_q.pad_enable;

endmodule

// File: tb/tb_cmd_phy_controller.sv
// Directed bench for cmd_phy_controller (TIMEOUT_CYCLES=8, MAX_RETRY=2).
// Inputs driven and outputs sampled on the falling edge of sd_clock.
module tb_cmd_phy_controller;

  localparam int unsigned RESP_W         = 136;
  localparam int unsigned SHORT_W        = 48;
  localparam int unsigned TIMEOUT_CYCLES = 8;
  localparam int unsigned MAX_RETRY      = 2;

  logic              sd_clock = 1'b0;
  logic              reset;
  logic              strobe_in, ack_in, idle_in, no_response, long_resp;
  logic [RESP_W-1:0] pad_response;
  logic              reception_complete, transmission_complete;
  logic              ack_out, strobe_out, command_timeout, load_send;
  logic              enable_pts_wrapper, enable_stp_wrapper, reset_wrapper;
  logic              pad_state, pad_enable, long_mode;
  logic [RESP_W-1:0] response;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 sd_clock = ~sd_clock;

  cmd_phy_controller #(
    .RESP_W(RESP_W), .SHORT_W(SHORT_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .sd_clock(sd_clock), .reset(reset),
    .strobe_in(strobe_in), .ack_in(ack_in), .idle_in(idle_in),
    .no_response(no_response), .long_resp(long_resp),
    .pad_response(pad_response),
    .reception_complete(reception_complete),
    .transmission_complete(transmission_complete),
    .ack_out(ack_out), .strobe_out(strobe_out), .response(response),
    .command_timeout(command_timeout), .load_send(load_send),
    .enable_pts_wrapper(enable_pts_wrapper),
    .enable_stp_wrapper(enable_stp_wrapper),
    .reset_wrapper(reset_wrapper), .pad_state(pad_state),
    .pad_enable(pad_enable), .long_mode(long_mode)
  );

  // tx: SEND cycles before transmission_complete; d: WAIT_RESP cycles before
  // reception_complete; exp_lat: edges from strobe_in to strobe_out
  typedef struct {
    logic              long_resp;
    logic              no_resp;
    logic [RESP_W-1:0] pad;
    int                tx;
    int                d;
    logic [RESP_W-1:0] exp_resp;
    logic              exp_to;
    logic              exp_long;
    int                exp_lat;
  } vec_t;

  localparam logic [9:0] IDLE_OUTS = 10'b00_0000_1000;

  function automatic logic [9:0] outs();
    return {ack_out, strobe_out, command_timeout, load_send, enable_pts_wrapper,
            enable_stp_wrapper, reset_wrapper, pad_state, pad_enable, long_mode};
  endfunction

  function automatic vec_t mk(input logic lr, input logic nr, input logic [RESP_W-1:0] pad,
                              input int tx, input int d, input logic [RESP_W-1:0] er,
                              input logic eto, input logic el, input int lat);
    vec_t v;
    v.long_resp = lr; v.no_resp = nr; v.pad = pad; v.tx = tx; v.d = d;
    v.exp_resp = er; v.exp_to = eto; v.exp_long = el; v.exp_lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [RESP_W-1:0] act,
                       input logic [RESP_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge sd_clock);
  endtask

  // Ack handshake from DELIVER back to IDLE
  task automatic finish_ack(input string tag);
    ack_in = 1'b1;
    tick();
    check({tag, " ack_strobe"}, {ack_out, strobe_out}, 2'b10);
    tick();
    check({tag, " ack_held"}, ack_out, 1'b1);
    strobe_in = 1'b0;
    ack_in    = 1'b0;
    tick();
    check({tag, " back_idle"}, outs(), IDLE_OUTS);
    check({tag, " resp_clr"}, response, '0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int    lat;
    bit    seen;
    string tag;
    tag = $sformatf("vec%0d", idx);
    strobe_in    = 1'b1;
    long_resp    = v.long_resp;
    no_response  = v.no_resp;
    pad_response = v.pad;
    lat  = 0;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      transmission_complete = (i == 2 + v.tx);
      reception_complete    = !v.no_resp && (i == 3 + v.tx + v.d);
      tick();
      lat = i + 1;
      // Mode inputs are only sampled at the start of the transaction
      if (i == 0) begin
        long_resp   = ~v.long_resp;
        no_response = ~v.no_resp;
      end
      if (lat == 1)
        check({tag, " load_outs"},
              {pad_enable, pad_state, enable_pts_wrapper, load_send, reset_wrapper}, 5'b11100);
      if (lat == 2) check({tag, " send_outs"}, {load_send, pad_enable}, 2'b11);
      if (strobe_out) seen = 1;
    end
    transmission_complete = 1'b0;
    reception_complete    = 1'b0;
    check({tag, " latency"}, lat, v.exp_lat);
    check({tag, " response"}, response, v.exp_resp);
    check({tag, " timeout"}, command_timeout, v.exp_to);
    check({tag, " long_mode"}, long_mode, v.exp_long);
    finish_ack(tag);
  endtask

  vec_t vecs[7];

  initial begin
    int loads, stp_lat, lat;
    bit seen;
    logic [RESP_W-1:0] a5, pat;
    a5  = {17{8'hA5}};
    pat = 136'hDE_ADBE_EFCA_FEF0_0D12_3456_789A_BCDE_F012;

    vecs[0] = mk(1'b0, 1'b0, '1,  1, 5, 136'hFFFF_FFFF_FFFF, 1'b0, 1'b0, 10);
    vecs[1] = mk(1'b1, 1'b0, a5,  0, 2, a5,                  1'b0, 1'b1, 6);
    vecs[2] = mk(1'b0, 1'b0, pat, 2, 0, 136'h789A_BCDE_F012, 1'b0, 1'b0, 6);
    vecs[3] = mk(1'b0, 1'b1, '1,  0, 0, '0,                  1'b0, 1'b0, 3);
    vecs[4] = mk(1'b1, 1'b0, pat, 0, 7, pat,                 1'b0, 1'b1, 11);
    vecs[5] = mk(1'b1, 1'b1, a5,  3, 0, '0,                  1'b0, 1'b1, 6);
    vecs[6] = mk(1'b0, 1'b0, pat, 1, 7, 136'h789A_BCDE_F012, 1'b0, 1'b0, 12);

    reset = 1'b0;
    {strobe_in, ack_in, idle_in, no_response, long_resp} = '0;
    {reception_complete, transmission_complete} = '0;
    pad_response = '0;
    tick();
    tick();
    check("reset_outs", outs(), IDLE_OUTS);
    check("reset_resp", response, '0);
    reset = 1'b1;
    tick();

    for (int k = 0; k < 7; k++) run_vec(k, vecs[k]);

    // Timeout without reception; tc pulsed whenever the DUT is shifting
    strobe_in = 1'b1; long_resp = 1'b1; no_response = 1'b0; pad_response = '1;
    loads = 0; stp_lat = -1; lat = 0; seen = 0;
    for (int i = 0; i < 80 && !seen; i++) begin
      transmission_complete = load_send;
      tick();
      lat = i + 1;
      if (enable_pts_wrapper && !load_send) loads++;
      if (enable_stp_wrapper && stp_lat < 0) stp_lat = lat;
      if (strobe_out) seen = 1;
    end
    transmission_complete = 1'b0;
`ifdef CMD_RETRY_EN
    check("to_loads", loads, 3);
    check("to_latency", lat, 31);
`else
    check("to_loads", loads, 1);
    check("to_latency", lat, 11);
    check("to_wait_len", lat - stp_lat, 8);
`endif
    check("to_flag", command_timeout, 1'b1);
    check("to_resp", response, '0);
    check("to_long_mode", long_mode, 1'b1);
    finish_ack("timeout");

    // idle_in mid-SEND aborts at once and blocks a new start
    strobe_in = 1'b1; long_resp = 1'b1;
    tick();
    tick();
    check("abort_in_send", load_send, 1'b1);
    idle_in = 1'b1;
    tick();
    check("abort_outs", outs(), IDLE_OUTS);
    tick();
    check("abort_hold_idle", outs(), IDLE_OUTS);
    strobe_in = 1'b0; idle_in = 1'b0;
    tick();

    // Asynchronous reset in WAIT_RESP
    strobe_in = 1'b1; long_resp = 1'b1;
    for (int i = 0; i < 5; i++) begin
      transmission_complete = (i == 2);
      tick();
    end
    transmission_complete = 1'b0;
    check("pre_reset_wait", {enable_stp_wrapper, long_mode, reset_wrapper}, 3'b110);
    reset = 1'b0;
    #1;
    check("async_reset_outs", outs(), IDLE_OUTS);
    check("async_reset_resp", response, '0);
    strobe_in = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("post_reset_idle", outs(), IDLE_OUTS);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
